// File: rtl/fp_div_pkg.sv
// Shared definitions for the iterative significand divider.
//   MANT_W : significand width including the hidden bit
//   Q_W    : quotient width (1 integer bit, MANT_W-1 fraction bits, 3 guard/round bits)
//   CNT_W  : quotient bit counter width
//   state_t: divider sequencing states
package fp_div_pkg;

  localparam int unsigned MANT_W = 53;
  localparam int unsigned Q_W    = MANT_W + 3;
  localparam int unsigned CNT_W  = $clog2(Q_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fp_div_step.sv
// One restoring-division iteration: compare, conditionally subtract, shift.
//   rem      : current partial remainder (W+1 bits)
//   divisor  : divisor significand (W bits)
//   rem_next : remainder for the next quotient bit position
//   q_bit    : quotient bit produced by this iteration
module fp_div_step #(
  parameter int unsigned W = 53
) (
  input  logic [W:0]   rem,
  input  logic [W-1:0] divisor,
  output logic [W:0]   rem_next,
  output logic         q_bit
);

  logic [W:0] divisor_ext;
  logic [W:0] diff;

  assign divisor_ext = {1'b0, divisor};
  assign q_bit       = (rem >= divisor_ext);
  assign diff        = q_bit ? (rem - divisor_ext) : rem;
  // diff < divisor < 2^W, so the left shift cannot lose a set bit
  assign rem_next    = diff << 1;

endmodule

// File: rtl/fp_div_iter.sv
// Iterative radix-2 significand divider, one quotient bit per cycle.
//   clk, rst_n  : clock, asynchronous active-low reset
//   in_valid    : operands present      in_ready  : block can accept operands
//   mant_a      : dividend significand  mant_b    : divisor significand
//   out_valid   : result present        out_ready : downstream accepts result
//   quotient    : floor(mant_a * 2^(Q_W-1) / mant_b)
//   sticky      : final remainder non-zero
//   div_by_zero : divisor hidden bit was clear at acceptance
module fp_div_iter #(
  parameter int unsigned MANT_W = fp_div_pkg::MANT_W,
  parameter int unsigned Q_W    = fp_div_pkg::Q_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] mant_a,
  input  logic [MANT_W-1:0] mant_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [Q_W-1:0]    quotient,
  output logic              sticky,
  output logic              div_by_zero
);

  import fp_div_pkg::*;

  localparam int unsigned CW = $clog2(Q_W);

  state_t            state;
  state_t            state_d;

  logic [MANT_W:0]   rem;
  logic [MANT_W:0]   rem_d;
  logic [MANT_W-1:0] divisor;
  logic [MANT_W-1:0] divisor_d;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_d;
  logic [Q_W-1:0]    quotient_d;
  logic              sticky_d;
  logic              div_by_zero_d;
  logic              in_ready_d;
  logic              out_valid_d;

  logic [MANT_W:0]   step_rem;
  logic              step_bit;
  logic              fire;

  assign fire = out_valid && out_ready;

  fp_div_step #(.W(MANT_W)) u_step (
    .rem      (rem),
    .divisor  (divisor),
    .rem_next (step_rem),
    .q_bit    (step_bit)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (in_valid) state_d = mant_b[MANT_W-1] ? CALC : DONE;
      CALC:    if (cnt == '0) state_d = DONE;
      DONE:    if (fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    in_ready_d    = (state_d == IDLE);
    // out_valid follows DONE by one edge, so the first DONE cycle cannot handshake
    out_valid_d   = (state == DONE) && !fire;
    rem_d         = rem;
    divisor_d     = divisor;
    cnt_d         = cnt;
    quotient_d    = quotient;
    sticky_d      = sticky;
    div_by_zero_d = div_by_zero;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          divisor_d     = mant_b;
          div_by_zero_d = !mant_b[MANT_W-1];
          sticky_d      = 1'b0;
          if (mant_b[MANT_W-1]) begin
            rem_d      = {1'b0, mant_a};
            quotient_d = '0;
            cnt_d      = CW'(Q_W - 1);
          end else begin
            rem_d      = '0;
            quotient_d = '1;
            cnt_d      = '0;
          end
        end
      end
      CALC: begin
        rem_d           = step_rem;
        quotient_d[cnt] = step_bit;
        cnt_d           = (cnt == '0) ? '0 : cnt - 1'b1;
      end
      DONE: begin
        // remainder is frozen in DONE; zero on the divide-by-zero path
        sticky_d = |rem;
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      sticky      <= 1'b0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      rem         <= '0;
      divisor     <= '0;
    end else begin
      in_ready    <= in_ready_d;
      out_valid   <= out_valid_d;
      quotient    <= quotient_d;
      sticky      <= sticky_d;
      div_by_zero <= div_by_zero_d;
      cnt         <= cnt_d;
      rem         <= rem_d;
      divisor     <= divisor_d;
    end
  end

endmodule

// File: tb/tb_fp_div_iter.sv
// Self-checking bench for fp_div_iter: directed table, handshake and reset
// corner sequences, and randomized operands against a wide-arithmetic model.
module tb_fp_div_iter;

  localparam int unsigned MW = 53;
  localparam int unsigned QW = 56;
  localparam int unsigned LAT_NORM = QW + 1;
  localparam int unsigned BOUND = 200;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [MW-1:0] mant_a = '0;
  logic [MW-1:0] mant_b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [QW-1:0] quotient;
  logic          sticky;
  logic          div_by_zero;

  int pass_cnt = 0;
  int total_cnt = 0;

  fp_div_iter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .mant_a      (mant_a),
    .mant_b      (mant_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .sticky      (sticky),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [MW-1:0] a;
    logic [MW-1:0] b;
    logic [QW-1:0] q;
    logic          s;
    logic          dz;
    int            lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else pass_cnt++;
  endtask

  // Quotient from the defining formula using wide integer division
  function automatic void model(input logic [MW-1:0] a, input logic [MW-1:0] b,
                                output logic [QW-1:0] q, output logic s, output logic dz);
    logic [127:0] num, den, qq, rr;
    if (!b[MW-1]) begin
      q = '1; s = 1'b0; dz = 1'b1;
    end else begin
      num = 128'(a) << (QW - 1);
      den = 128'(b);
      qq  = num / den;
      rr  = num % den;
      q   = qq[QW-1:0];
      s   = (rr != 0);
      dz  = 1'b0;
    end
  endfunction

  // Present operands and return just after the accepting edge
  task automatic start_op(input logic [MW-1:0] a, input logic [MW-1:0] b);
    int guard = 0;
    @(negedge clk);
    while (!in_ready && guard < BOUND) begin @(negedge clk); guard++; end
    mant_a = a; mant_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count edges after acceptance until out_valid is seen (bounded)
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < BOUND) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_op(input logic [MW-1:0] a, input logic [MW-1:0] b,
                        output logic [QW-1:0] q, output logic s, output logic dz, output int lat);
    start_op(a, b);
    wait_valid(lat);
    q = quotient; s = sticky; dz = div_by_zero;
    handshake();
  endtask

  initial begin
    vec_t          vecs[6];
    logic [QW-1:0] q, eq;
    logic          s, dz, es, edz;
    int            lat;
    logic [MW-1:0] ra, rb;
    logic          seen;

    vecs[0] = '{53'h10000000000000, 53'h10000000000000, 56'h80000000000000, 1'b0, 1'b0, LAT_NORM};
    vecs[1] = '{53'h10000000000000, 53'h18000000000000, 56'h55555555555555, 1'b1, 1'b0, LAT_NORM};
    vecs[2] = '{53'h1FFFFFFFFFFFFF, 53'h10000000000000, 56'hFFFFFFFFFFFFF8, 1'b0, 1'b0, LAT_NORM};
    vecs[3] = '{53'h10000000000000, 53'h00000000000000, 56'hFFFFFFFFFFFFFF, 1'b0, 1'b1, 1};
    vecs[4] = '{53'h1ABCDEF0123456, 53'h0FFFFFFFFFFFFF, 56'hFFFFFFFFFFFFFF, 1'b0, 1'b1, 1};
    vecs[5] = '{53'h18000000000000, 53'h10000000000000, 56'hC0000000000000, 1'b0, 1'b0, LAT_NORM};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_quotient", 64'(quotient), 64'd0);
    check("rst_sticky", 64'(sticky), 64'd0);
    check("rst_dbz", 64'(div_by_zero), 64'd0);
    @(negedge clk) rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, q, s, dz, lat);
      check($sformatf("vec%0d_quotient", i), 64'(q), 64'(vecs[i].q));
      check($sformatf("vec%0d_sticky", i), 64'(s), 64'(vecs[i].s));
      check($sformatf("vec%0d_dbz", i), 64'(dz), 64'(vecs[i].dz));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
    end

    // Stalled result, ignored input in DONE, then back-to-back operation
    model(53'h1C000000000001, 53'h13333333333333, eq, es, edz);
    start_op(53'h1C000000000001, 53'h13333333333333);
    wait_valid(lat);
    check("stall_latency", 64'(lat), 64'(LAT_NORM));
    mant_a = 53'h10000000000000; mant_b = '0; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("stall%0d_out_valid", i), 64'(out_valid), 64'd1);
      check($sformatf("stall%0d_in_ready", i), 64'(in_ready), 64'd0);
      check($sformatf("stall%0d_quotient", i), 64'(quotient), 64'(eq));
      check($sformatf("stall%0d_flags", i), 64'({sticky, div_by_zero}), 64'({es, edz}));
    end
    in_valid = 1'b0;
    @(negedge clk);
    handshake();
    check("hs_out_valid", 64'(out_valid), 64'd0);
    check("hs_in_ready", 64'(in_ready), 64'd1);
    model(53'h1FFFFFFFFFFFFF, 53'h1FFFFFFFFFFFFE, eq, es, edz);
    mant_a = 53'h1FFFFFFFFFFFFF; mant_b = 53'h1FFFFFFFFFFFFE; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("b2b_accepted", 64'(in_ready), 64'd0);
    wait_valid(lat);
    check("b2b_latency", 64'(lat), 64'(LAT_NORM));
    check("b2b_quotient", 64'(quotient), 64'(eq));
    check("b2b_sticky", 64'(sticky), 64'(es));
    handshake();

    // Reset in the middle of CALC
    start_op(53'h1234567890ABCD | 53'h10000000000000, 53'h1FEDCBA9876543);
    repeat (20) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_outputs", 64'({in_ready, out_valid, sticky, div_by_zero}), 64'(4'b1000));
    check("midrst_quotient", 64'(quotient), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("midrst_no_result", 64'(seen), 64'd0);
    model(53'h15555555555555, 53'h1AAAAAAAAAAAAB, eq, es, edz);
    run_op(53'h15555555555555, 53'h1AAAAAAAAAAAAB, q, s, dz, lat);
    check("postrst_quotient", 64'(q), 64'(eq));
    check("postrst_sticky", 64'(s), 64'(es));
    check("postrst_latency", 64'(lat), 64'(LAT_NORM));

    // Randomized operands against the model
    for (int i = 0; i < 30; i++) begin
      ra = {1'b1, 20'($urandom), 32'($urandom)};
      rb = {1'b1, 20'($urandom), 32'($urandom)};
      if ((i % 7) == 3) rb[MW-1] = 1'b0;
      if ((i % 5) == 1) ra = rb | 53'h10000000000000;
      model(ra, rb, eq, es, edz);
      run_op(ra, rb, q, s, dz, lat);
      check($sformatf("rnd%0d_quotient", i), 64'(q), 64'(eq));
      check($sformatf("rnd%0d_flags", i), 64'({s, dz}), 64'({es, edz}));
      check($sformatf("rnd%0d_latency", i), 64'(lat), edz ? 64'd1 : 64'(LAT_NORM));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
